// File: rtl/pixel_stream_gen.sv
// Test-pattern pixel source: WIDTH x HEIGHT frames on a valid/ready stream with sof/eol/eof markers.
// Registered outputs, first pixel one cycle after start; pixel and markers hold while the sink stalls.
module pixel_stream_gen #(
  parameter int          WIDTH      = 16,
  parameter int          HEIGHT     = 16,
  parameter int          GAP_CYCLES = 4,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  input  logic [1:0]  pattern,
  input  logic [7:0]  const_val,
  output logic [7:0]  pix_out,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t          state, nstate;
  logic [XW-1:0]   x, nx;
  logic [YW-1:0]   y, ny;
  logic [7:0]      lfsr, lfsr_nxt;
  logic [1:0]      pat_sh;
  logic [7:0]      const_sh;
  logic [GW-1:0]   gap_cnt;
  logic [15:0]     frame_cnt_q;
  logic            xfer, gap_last, load;

  assign frame_cnt = frame_cnt_q;

  function automatic logic [7:0] pix_fn(input logic [1:0] p, input logic [7:0] c,
                                        input logic [XW-1:0] px, input logic [YW-1:0] py,
                                        input logic [7:0] l);
    logic [31:0] blk;
    blk = (32'(px) >> 3) ^ (32'(py) >> 3);
    case (p)
      2'b00:   pix_fn = 8'(px) + 8'(py);
      2'b01:   pix_fn = blk[0] ? 8'hFF : 8'h00;
      2'b10:   pix_fn = l;
      default: pix_fn = c;
    endcase
  endfunction

  // Fibonacci taps for x^8+x^6+x^5+x^4+1
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign nx = (x == XW'(WIDTH - 1)) ? '0 : x + 1'b1;
  assign ny = (x == XW'(WIDTH - 1)) ? ((y == YW'(HEIGHT - 1)) ? '0 : y + 1'b1) : y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = STREAM;
      STREAM:  if (xfer && eof) nstate = GAP;
      GAP:     if (gap_last) nstate = cont ? STREAM : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    xfer     = (state == STREAM) && pix_valid && pix_ready;
    gap_last = (state == GAP) && (gap_cnt == GW'(GAP_CYCLES - 1));
    load     = ((state == IDLE) && start) || (gap_last && cont);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      lfsr        <= LFSR_SEED;
      pat_sh      <= 2'b00;
      const_sh    <= 8'h00;
      gap_cnt     <= '0;
      frame_cnt_q <= 16'h0000;
      frame_done  <= 1'b0;
      pix_out     <= 8'h00;
      pix_valid   <= 1'b0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      eof         <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        // shadow regs isolate the running frame from input changes
        pat_sh    <= pattern;
        const_sh  <= const_val;
        x         <= '0;
        y         <= '0;
        lfsr      <= LFSR_SEED;
        pix_out   <= pix_fn(pattern, const_val, '0, '0, LFSR_SEED);
        pix_valid <= 1'b1;
        sof       <= 1'b1;
        eol       <= 1'b0;
        eof       <= 1'b0;
      end else if (xfer) begin
        if (eof) begin
          x           <= '0;
          y           <= '0;
          gap_cnt     <= '0;
          pix_out     <= 8'h00;
          pix_valid   <= 1'b0;
          sof         <= 1'b0;
          eol         <= 1'b0;
          eof         <= 1'b0;
          frame_done  <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
          x       <= nx;
          y       <= ny;
          lfsr    <= lfsr_nxt;
          pix_out <= pix_fn(pat_sh, const_sh, nx, ny, lfsr_nxt);
          sof     <= 1'b0;
          eol     <= (nx == XW'(WIDTH - 1));
          eof     <= (nx == XW'(WIDTH - 1)) && (ny == YW'(HEIGHT - 1));
        end
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Bench for pixel_stream_gen: a frame-level reference model built from the pattern rules,
// compared against transfers captured at the stream interface under varied ready patterns.
module tb_pixel_stream_gen;
  localparam int W = 4, H = 2, GAPC = 4;

  logic clk = 0, rst = 1, start = 0, cont = 0, pix_ready = 0;
  logic [1:0] pattern = 0;
  logic [7:0] const_val = 0, pix_out;
  logic pix_valid, sof, eol, eof, busy, frame_done;
  logic [15:0] frame_cnt;

  pixel_stream_gen #(.WIDTH(W), .HEIGHT(H), .GAP_CYCLES(GAPC), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .pattern(pattern),
    .const_val(const_val), .pix_out(pix_out), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [10:0] obs[$], exp_q[$];
  int gaps[$], fcq[$];
  int stall_bad, bubbles, done_cnt, exp_fc;
  bit timed_out;

  // Reference frame: pixels in raster order, each word {sof,eol,eof,pixel}
  task automatic build_frame(input int p, input logic [7:0] c);
    logic [7:0] lf, v;
    lf = 8'hA5;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        case (p)
          0: v = 8'((xx + yy) % 256);
          1: v = (((xx / 8) ^ (yy / 8)) % 2 == 1) ? 8'hFF : 8'h00;
          2: v = lf;
          default: v = c;
        endcase
        exp_q.push_back({xx == 0 && yy == 0, xx == W - 1, xx == W - 1 && yy == H - 1, v});
        lf = {lf[6:0], ^(lf & 8'hB8)};
      end
  endtask

  task automatic do_start(input logic [1:0] p, input logic [7:0] c);
    pattern = p; const_val = c; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // Drives ready (0: always, 1: toggling, 2: random) and records what the stream delivers.
  task automatic collect(input int nframes, input int rmode, input int chg_at,
                         input logic [1:0] np, input logic [7:0] nc);
    int eofs = 0, tail = 0, cyc = 0, nxf = 0, gap_len = 0;
    bit in_gap = 0, started = 0, prev_stall = 0, r;
    logic [10:0] w, prev_word = '0;
    obs.delete(); gaps.delete(); fcq.delete();
    stall_bad = 0; bubbles = 0; done_cnt = 0; timed_out = 0;
    while (cyc < 2000) begin
      w = {sof, eol, eof, pix_out};
      if (frame_done) begin done_cnt++; fcq.push_back(int'(frame_cnt)); end
      if (prev_stall && (!pix_valid || w !== prev_word)) stall_bad++;
      if (pix_valid) begin
        if (in_gap && sof) begin gaps.push_back(gap_len); in_gap = 0; end
      end else if (in_gap) gap_len++;
      else if (started) bubbles++;
      case (rmode)
        0: r = 1;
        1: r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      pix_ready = r;
      prev_stall = 0;
      if (pix_valid) begin
        started = 1;
        if (r) begin
          obs.push_back(w);
          nxf++;
          if (nxf == chg_at) begin pattern = np; const_val = nc; end
          if (eof) begin
            eofs++; in_gap = 1; gap_len = 0;
            if (eofs == nframes) cont = 0;
          end
        end else begin
          prev_stall = 1; prev_word = w;
        end
      end
      if (eofs == nframes) begin tail++; if (tail > 2) break; end
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 2000) timed_out = 1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (busy) begin miscompares++; $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n); end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({pix_out, pix_valid, sof, eol, eof, busy, frame_done, frame_cnt} !== 30'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got pix=%h v=%b sof=%b eol=%b eof=%b busy=%b done=%b cnt=%h, want all 0",
               pix_out, pix_valid, sof, eol, eof, busy, frame_done, frame_cnt);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    do_start(2'b00, 8'h00);
    vectors++;
    if ({pix_valid, sof, busy, pix_out} !== {3'b111, 8'h00}) begin
      miscompares++;
      $display("FAIL start_latency: got v=%b sof=%b busy=%b pix=%h, want 1 1 1 00", pix_valid, sof, busy, pix_out);
    end
    collect(1, 0, -1, 0, 0);
    exp_q.delete(); build_frame(0, 0);
    vectors++;
    if (obs.size() != W * H || timed_out) begin miscompares++; $display("FAIL ramp_count: got %0d transfers, want %0d", obs.size(), W * H); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] g;
      g = (i < obs.size()) ? obs[i] : 'x;
      vectors++;
      if (g !== exp_q[i]) begin miscompares++; $display("FAIL ramp_pix[%0d]: got %h want %h", i, g, exp_q[i]); end
    end
    exp_fc++;
    vectors++;
    if (done_cnt != 1 || fcq.size() != 1 || fcq[0] != exp_fc) begin
      miscompares++; $display("FAIL ramp_done: got pulses=%0d cnt=%0d, want 1 and %0d", done_cnt, (fcq.size() > 0) ? fcq[0] : -1, exp_fc);
    end
    vectors++;
    if (bubbles != 0) begin miscompares++; $display("FAIL back_to_back: got %0d bubbles, want 0", bubbles); end
    wait_idle();
  endtask

  task automatic test_stall_const();
    do_start(2'b11, 8'h5A);
    collect(1, 1, 4, 2'b11, 8'hC3);
    exp_q.delete(); build_frame(3, 8'h5A);
    vectors++;
    if (obs.size() != W * H || timed_out) begin miscompares++; $display("FAIL stall_count: got %0d transfers, want %0d", obs.size(), W * H); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] g;
      g = (i < obs.size()) ? obs[i] : 'x;
      vectors++;
      if (g !== exp_q[i]) begin miscompares++; $display("FAIL const_pix[%0d]: got %h want %h", i, g, exp_q[i]); end
    end
    vectors++;
    if (stall_bad != 0) begin miscompares++; $display("FAIL stall_stable: got %0d unstable stalls, want 0", stall_bad); end
    exp_fc++;
    vectors++;
    if (done_cnt != 1 || fcq.size() != 1 || fcq[0] != exp_fc) begin
      miscompares++; $display("FAIL stall_done: got pulses=%0d, want 1 with cnt %0d", done_cnt, exp_fc);
    end
    wait_idle();
  endtask

  task automatic test_lfsr_cont();
    cont = 1;
    do_start(2'b10, 8'($urandom));
    collect(2, 2, -1, 0, 0);
    exp_q.delete(); build_frame(2, 0); build_frame(2, 0);
    vectors++;
    if (obs.size() != 2 * W * H || timed_out) begin miscompares++; $display("FAIL lfsr_count: got %0d transfers, want %0d", obs.size(), 2 * W * H); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] g;
      g = (i < obs.size()) ? obs[i] : 'x;
      vectors++;
      if (g !== exp_q[i]) begin miscompares++; $display("FAIL lfsr_pix[%0d]: got %h want %h", i, g, exp_q[i]); end
    end
    vectors++;
    if (stall_bad != 0 || bubbles != 0) begin miscompares++; $display("FAIL lfsr_stream: got stalls_bad=%0d bubbles=%0d, want 0 0", stall_bad, bubbles); end
    wait_idle();
    exp_fc += 2;
  endtask

  task automatic test_gap_pattern_change();
    cont = 1;
    do_start(2'b00, 8'h00);
    collect(3, 2, 3, 2'b11, 8'h33);
    exp_q.delete(); build_frame(0, 0); build_frame(3, 8'h33); build_frame(3, 8'h33);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] g;
      g = (i < obs.size()) ? obs[i] : 'x;
      vectors++;
      if (g !== exp_q[i]) begin miscompares++; $display("FAIL chg_pix[%0d]: got %h want %h", i, g, exp_q[i]); end
    end
    vectors++;
    if (gaps.size() != 2 || gaps[0] != GAPC || gaps[1] != GAPC) begin
      miscompares++; $display("FAIL gap_len: got n=%0d first=%0d, want 2 gaps of %0d", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1, GAPC);
    end
    for (int i = 0; i < 3; i++) begin
      int g;
      g = (i < fcq.size()) ? fcq[i] : -1;
      vectors++;
      if (g != exp_fc + i + 1) begin miscompares++; $display("FAIL frame_cnt[%0d]: got %0d want %0d", i, g, exp_fc + i + 1); end
    end
    exp_fc += 3;
    wait_idle();
  endtask

  task automatic test_async_reset();
    int xf = 0, n = 0;
    do_start(2'b00, 8'h00);
    pix_ready = 1;
    while (xf < 4 && n < 50) begin
      if (pix_valid) xf++;
      n++;
      @(negedge clk);
    end
    #2 rst = 1;
    #1;
    vectors++;
    if ({pix_out, pix_valid, sof, eol, eof, busy, frame_done, frame_cnt} !== 30'd0 || xf != 4) begin
      miscompares++;
      $display("FAIL async_reset: got pix=%h v=%b busy=%b cnt=%h xfers=%0d, want all 0 after 4 xfers",
               pix_out, pix_valid, busy, frame_cnt, xf);
    end
    @(negedge clk);
    start = 1;
    @(negedge clk);
    rst = 0; start = 0;
    @(negedge clk);
    vectors++;
    if ({pix_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL rst_wins: got v=%b busy=%b, want 0 0", pix_valid, busy);
    end
    do_start(2'b00, 8'h00);
    vectors++;
    if ({pix_valid, sof, pix_out, frame_cnt} !== {2'b11, 8'h00, 16'h0000}) begin
      miscompares++; $display("FAIL post_rst_start: got v=%b sof=%b pix=%h cnt=%h, want 1 1 00 0000", pix_valid, sof, pix_out, frame_cnt);
    end
    collect(1, 2, -1, 0, 0);
    vectors++;
    if (obs.size() != W * H || fcq.size() != 1 || fcq[0] != 1) begin
      miscompares++; $display("FAIL post_rst_frame: got xfers=%0d cnt=%0d, want %0d and 1", obs.size(), (fcq.size() > 0) ? fcq[0] : -1, W * H);
    end
    exp_fc = 1;
    wait_idle();
  endtask

  task automatic test_wrap();
    logic [1:0] p;
    logic [7:0] c;
    p = 2'($urandom); c = 8'($urandom);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    do_start(p, c);
    collect(1, 2, -1, 0, 0);
    exp_q.delete(); build_frame(int'(p), c);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] g;
      g = (i < obs.size()) ? obs[i] : 'x;
      vectors++;
      if (g !== exp_q[i]) begin miscompares++; $display("FAIL wrap_pix[%0d] pat=%0d: got %h want %h", i, p, g, exp_q[i]); end
    end
    vectors++;
    if (done_cnt != 1 || fcq.size() != 1 || fcq[0] != 0) begin
      miscompares++; $display("FAIL cnt_wrap: got pulses=%0d cnt=%0d, want 1 and 0", done_cnt, (fcq.size() > 0) ? fcq[0] : -1);
    end
    wait_idle();
  endtask

  initial begin
    exp_fc = 0;
    test_reset();
    test_ramp();
    test_stall_const();
    test_lfsr_cont();
    test_gap_pattern_change();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
